// File: rtl/main_memory_responder_pkg.sv
// Shared types for the data-cache backing store: line type, FSM states, line-size default.
package main_memory_responder_pkg;

   localparam int unsigned LINE_WORDS_DEF = 4;

   typedef logic [31:0]                   V32;
   typedef logic [32*LINE_WORDS_DEF-1:0]  t_line;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } t_mem_state;

   // Width of an index into n entries, never below one bit.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/main_memory_responder_mem_line_array.sv
// DEPTH x line storage with one registered read/write port; only the read register is reset.
module mem_line_array
   import main_memory_responder_pkg::*;
#(
   parameter int unsigned LINE_W = 32*LINE_WORDS_DEF,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = idx_bits(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [LINE_W-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (en_i && we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Read data persists between fills so the cache can sample it late.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model servicing cache line fills and write-backs.
// Optional MEM_TRACE_EN prints each completion on the falling clock edge.
//
//   state | meaning
//   IDLE  | waiting for req_valid; request latched on acceptance
//   WAIT  | latency countdown in progress
//   DONE  | one-cycle completion; storage accessed on entry edge
module main_memory_responder
   import main_memory_responder_pkg::*;
#(
   parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic                    req_write,
   input  logic [31:0]             req_addr,
   input  logic [32*LINE_WORDS-1:0] req_wdata,
   output logic                    mem_busy,
   output logic                    mem_done,
   output logic [32*LINE_WORDS-1:0] resp_rdata
);

   localparam int unsigned LINE_W = 32*LINE_WORDS;
   localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
   localparam int unsigned IDX_W  = idx_bits(DEPTH);
   localparam int unsigned CNT_W  = idx_bits(LATENCY) + 1;

   t_mem_state         state_q;
   logic [CNT_W-1:0]   count_q;
   logic               busy_q;
   logic               done_q;
   logic               write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [LINE_W-1:0]  wdata_q;

   logic [IDX_W-1:0]   req_idx;
   logic               acc_en;
   logic               acc_we;
   logic [IDX_W-1:0]   acc_idx;
   logic [LINE_W-1:0]  acc_wdata;
   logic               unused_addr_bits;

   // Upper address bits alias modulo DEPTH lines; offset bits select nothing.
   assign req_idx          = req_addr[OFF_W +: IDX_W];
   assign unused_addr_bits = ^{req_addr[31:OFF_W+IDX_W], req_addr[OFF_W-1:0]};

   // Storage is touched only on the edge that enters DONE; a single-cycle
   // latency build has to use the live request since nothing is latched yet.
   always_comb begin
      acc_en    = 1'b0;
      acc_we    = write_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      if (state_q == IDLE) begin
         acc_en    = req_valid && (LATENCY == 1);
         acc_we    = req_write;
         acc_idx   = req_idx;
         acc_wdata = req_wdata;
      end else if (state_q == WAIT) begin
         acc_en = (count_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (req_valid) begin
                  write_q <= req_write;
                  idx_q   <= req_idx;
                  wdata_q <= req_wdata;
                  count_q <= CNT_W'(LATENCY - 1);
                  busy_q  <= 1'b1;
                  if (LATENCY == 1) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (count_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
               count_q <= count_q - CNT_W'(1);
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   mem_line_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .en_i    (acc_en),
      .we_i    (acc_we),
      .idx_i   (acc_idx),
      .wdata_i (acc_wdata),
      .rdata_o (resp_rdata)
   );

   assign mem_busy = busy_q;
   assign mem_done = done_q;

`ifdef MEM_TRACE_EN
   always @(negedge clock) begin
      if (reset && done_q) begin
         $display("MEM_RSP %s idx=%0d data=%h", write_q ? "W" : "R", idx_q,
                  write_q ? wdata_q : resp_rdata);
      end
   end
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: read-data scoreboard, latency and busy-gap checks.
module tb_main_memory_responder;
   import main_memory_responder_pkg::*;

   localparam int LW     = 4;
   localparam int LINE_W = 32*LW;
   localparam int LAT    = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;

   logic              v0, w0, busy0, done0;
   logic [31:0]       a0;
   logic [LINE_W-1:0] wd0, rd0;
   logic              v1, w1, busy1, done1;
   logic [31:0]       a1;
   logic [LINE_W-1:0] wd1, rd1;

   always #5 clk = ~clk;

   main_memory_responder #(.LINE_WORDS(LW), .DEPTH(256), .LATENCY(LAT)) dut (
      .clock(clk), .reset(rst_n), .req_valid(v0), .req_write(w0), .req_addr(a0),
      .req_wdata(wd0), .mem_busy(busy0), .mem_done(done0), .resp_rdata(rd0));

   main_memory_responder #(.LINE_WORDS(LW), .DEPTH(256), .LATENCY(1)) dut1 (
      .clock(clk), .reset(rst_n), .req_valid(v1), .req_write(w1), .req_addr(a1),
      .req_wdata(wd1), .mem_busy(busy1), .mem_done(done1), .resp_rdata(rd1));

   int errors = 0;
   int checks = 0;

   typedef struct {
      string             tag;
      logic [LINE_W-1:0] data;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sel picks the LATENCY=1 instance. For reads, data is the expected line.
   // b2b: issued in the done cycle of a held previous request.
   task automatic do_req(input bit sel, input bit wr, input logic [31:0] addr,
                         input logic [LINE_W-1:0] data, input bit hold,
                         input bit b2b, input string tag);
      exp_t e;
      int   k, low, lat;
      bit   got;
      lat = sel ? 1 : LAT;
      if (!b2b) begin
         @(negedge clk);
         check({tag, " idle busy"}, sel ? busy1 : busy0, '0);
         check({tag, " idle done"}, sel ? done1 : done0, '0);
      end
      if (!wr) begin
         e.tag  = {tag, " rdata"};
         e.data = data;
         sb.push_back(e);
      end
      if (sel) begin
         v1 = 1'b1; w1 = wr; a1 = addr; wd1 = wr ? data : ~data;
      end else begin
         v0 = 1'b1; w0 = wr; a0 = addr; wd0 = wr ? data : ~data;
      end
      k = 0; low = 0; got = 1'b0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (!(sel ? busy1 : busy0)) low++;
         if (sel ? done1 : done0) got = 1'b1;
         else if (sel ? busy1 : busy0) begin
            // Request fields must be latched; scramble them while in flight.
            if (sel) begin a1 = ~a1; wd1 = ~wd1; w1 = ~w1; end
            else     begin a0 = ~a0; wd0 = ~wd0; w0 = ~w0; end
         end
      end
      check({tag, " done seen"}, LINE_W'(got), LINE_W'(1));
      check({tag, " latency"}, LINE_W'(k), LINE_W'(b2b ? lat + 1 : lat));
      check({tag, " busy low cycles"}, LINE_W'(low), LINE_W'(b2b ? 1 : 0));
      if (!wr) begin
         e = sb.pop_front();
         check(e.tag, sel ? rd1 : rd0, e.data);
      end
      if (!hold) begin
         if (sel) v1 = 1'b0; else v0 = 1'b0;
      end
   endtask

   logic [LINE_W-1:0] l1, l2, l3, l4, ldead;
   int                stray;

   initial begin
      v0 = 0; w0 = 0; a0 = '0; wd0 = '0;
      v1 = 0; w1 = 0; a1 = '0; wd1 = '0;
      l1    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      l2    = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 32'h9ABCDEF0};
      l3    = {32'hCAFEF00D, 32'h01020304, 32'hFFFFFFFF, 32'h80000001};
      l4    = {32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};
      ldead = {4{32'hDEADBEEF}};

      repeat (3) @(negedge clk);
      check("reset busy", busy0, '0);
      check("reset done", done0, '0);
      check("reset rdata", rd0, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset busy", busy0, '0);
      check("post-reset done", done0, '0);
      check("post-reset rdata", rd0, '0);

      do_req(0, 1, 32'h40, l1, 0, 0, "wr 0x40");
      do_req(0, 0, 32'h40, l1, 0, 0, "rd 0x40");
      check("rd 0x40 word0", LINE_W'(rd0[31:0]), LINE_W'(32'h11111111));

      do_req(0, 1, 32'h80, l2, 0, 0, "wr 0x80");
      check("rdata held across write", rd0, l1);
      do_req(0, 0, 32'h8C, l2, 0, 0, "rd 0x8C offset");
      do_req(0, 0, 32'h1080, l2, 0, 0, "rd 0x1080 alias");

      do_req(0, 1, 32'hC0, l3, 1, 0, "held wr 0xC0");
      do_req(0, 0, 32'hC0, l3, 0, 1, "b2b rd 0xC0");

      do_req(0, 1, 32'h100, '0, 0, 0, "wr 0x100 zero");
      @(negedge clk);
      v0 = 1'b1; w0 = 1'b1; a0 = 32'h100; wd0 = ldead;
      repeat (2) @(negedge clk);
      check("mid-write busy before reset", busy0, LINE_W'(1));
      rst_n = 1'b0;
      v0 = 1'b0;
      #1;
      check("async reset busy", busy0, '0);
      check("async reset done", done0, '0);
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (done0) stray++;
      end
      rst_n = 1'b1;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (done0 || busy0) stray++;
      end
      check("no done after abandoned write", LINE_W'(stray), '0);
      do_req(0, 0, 32'h100, '0, 0, 0, "rd 0x100 after reset");

      do_req(1, 1, 32'h40, l4, 0, 0, "lat1 wr 0x40");
      do_req(1, 0, 32'h40, l4, 0, 0, "lat1 rd 0x40");
      check("lat1 leaves lat4 store intact", rd0, '0);
      do_req(0, 0, 32'h40, l1, 0, 0, "rd 0x40 again");

      check("scoreboard drained", LINE_W'(sb.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
